// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types and helpers for the board reset sequencer.
//   seq_state_t : sequencer FSM encoding, also driven onto the seq_state debug port
//   SEQ_STATE_W : width of the seq_state port
//   cnt_width() : bit width of a down-counter that reloads to (limit-1)

package reset_seq_pkg;

    localparam int SEQ_STATE_W = 2;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_HOLD  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_t;

    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// reset_debounce
//   Two-flop synchroniser followed by a stable-count filter. The output only
//   follows the synchronised input after DEBOUNCE_CYCLES consecutive samples
//   that differ from the current output; shorter excursions are discarded.
//   Both edges are filtered the same way.
// Ports
//   clk      : system clock
//   reset_n  : synchronous active-low reset (sync flops -> 0, dout -> INIT_LEVEL)
//   din      : asynchronous raw input
//   dout     : debounced, synchronous output

module reset_debounce
    import reset_seq_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 65536,
    parameter logic INIT_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int             CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt_q;

    // cnt_q counts down the remaining disagreeing samples; any agreeing sample
    // restarts the window so only an unbroken run can flip the output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= RELOAD;
            dout    <= INIT_LEVEL;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            if (sync_q2 == dout) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                dout  <= sync_q2;
                cnt_q <= RELOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Board-level reset controller. Waits for a synchronised PLL lock and a
//   debounced, released reset key, then releases CHANNELS reset domains one by
//   one (ch0 first), STAGE_DELAY cycles apart. Any fault drops every domain at
//   once and the sequence restarts from HOLD.
//   Optional watchdog: define RESET_SEQ_WDOG_EN to make a missing wdog_kick
//   within WDOG_CYCLES cycles of RUN a fault.
// Ports
//   clk        : system clock
//   reset_n    : synchronous active-low reset
//   pll_locked : async PLL lock, two-flop synchronised here
//   key_n      : async reset button (low = pressed), synchronised + debounced
//   wdog_kick  : one-cycle watchdog restart pulse (unused without the macro)
//   rst_out_n  : per-domain active-low resets, registered
//   all_ready  : high in RUN, i.e. every domain released
//   seq_state  : current FSM state for debug/LEDs
//
// state | meaning
// HOLD  | all domains in reset, waiting for lock and released key
// DELAY | releasing domains, one per STAGE_DELAY cycles
// RUN   | all domains released, all_ready high

module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS        = 3,
    parameter int STAGE_DELAY     = 1024,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int WDOG_CYCLES     = 2**24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   key_n,
    input  logic                   wdog_kick,
    output logic [CHANNELS-1:0]    rst_out_n,
    output logic                   all_ready,
    output logic [SEQ_STATE_W-1:0] seq_state
);

    localparam int             DW           = cnt_width(STAGE_DELAY);
    localparam logic [DW-1:0]  DELAY_RELOAD = DW'(STAGE_DELAY - 1);
    localparam int             IW           = cnt_width(CHANNELS);
    localparam logic [IW-1:0]  LAST_IDX     = IW'(CHANNELS - 1);

    seq_state_t          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       dly_q, dly_d;
    logic [CHANNELS-1:0] rst_q, rst_d;

    logic lock_q1;
    logic lock_s;
    logic key_db;
    logic wdog_fault;
    logic fault;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_q1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_q1 <= pll_locked;
            lock_s  <= lock_q1;
        end
    end

    reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .INIT_LEVEL      (1'b1)
    ) u_key_db (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (key_n),
        .dout    (key_db)
    );

`ifdef RESET_SEQ_WDOG_EN
    localparam int            WW          = cnt_width(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_RELOAD = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_q;

    // Down-counter sits at full reload outside RUN so each RUN entry gets the
    // whole timeout window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_q <= WDOG_RELOAD;
        end else if (state_q != ST_RUN || wdog_kick) begin
            wdog_q <= WDOG_RELOAD;
        end else if (wdog_q != '0) begin
            wdog_q <= wdog_q - 1'b1;
        end
    end

    // A kick arriving in the expiry cycle still rescues the system.
    assign wdog_fault = (state_q == ST_RUN) && (wdog_q == '0) && !wdog_kick;
`else
    logic unused_wdog;
    assign unused_wdog = wdog_kick | (WDOG_CYCLES < 2);
    assign wdog_fault  = 1'b0;
`endif

    assign fault = !lock_s || !key_db || wdog_fault;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        rst_d   = rst_q;

        case (state_q)
            ST_HOLD: begin
                rst_d = '0;
                idx_d = '0;
                dly_d = DELAY_RELOAD;
                if (!fault) begin
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (fault) begin
                    // Checked before the release so a coincident fault wins.
                    state_d = ST_HOLD;
                    rst_d   = '0;
                    idx_d   = '0;
                end else if (dly_q == '0) begin
                    rst_d = rst_q | (CHANNELS'(1) << idx_q);
                    dly_d = DELAY_RELOAD;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_RUN: begin
                rst_d = '1;
                if (fault) begin
                    state_d = ST_HOLD;
                    rst_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                rst_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_HOLD;
            idx_q   <= '0;
            dly_q   <= DELAY_RELOAD;
            rst_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            rst_q   <= rst_d;
        end
    end

    assign rst_out_n = rst_q;
    assign all_ready = (state_q == ST_RUN);
    assign seq_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer with CHANNELS=3, STAGE_DELAY=8,
//   DEBOUNCE_CYCLES=4, WDOG_CYCLES=32. A vector table covers power-up and a
//   key glitch; hand-written sequences cover key press, lock drop, fault at
//   the final release edge, mid-sequence reset and the watchdog
//   (RESET_SEQ_WDOG_EN) or its absence.

module tb_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       key_n;
    logic       wdog_kick;
    logic [2:0] rst_out_n;
    logic       all_ready;
    logic [1:0] seq_state;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    reset_sequencer #(
        .CHANNELS        (3),
        .STAGE_DELAY     (8),
        .DEBOUNCE_CYCLES (4),
        .WDOG_CYCLES     (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .key_n      (key_n),
        .wdog_kick  (wdog_kick),
        .rst_out_n  (rst_out_n),
        .all_ready  (all_ready),
        .seq_state  (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       lock;
        logic       key;
        int         cycles;
        logic [2:0] exp_rst;
        logic       exp_ready;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs [12];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [2:0] er,
                         input logic ea, input logic [1:0] es);
        checks++;
        if (rst_out_n !== er || all_ready !== ea || seq_state !== es) begin
            errors++;
            $display("FAIL %s: got rst_out_n=%b all_ready=%b seq_state=%0d, expected rst_out_n=%b all_ready=%b seq_state=%0d",
                     name, rst_out_n, all_ready, seq_state, er, ea, es);
        end
    endtask

    // Channels must always form a thermometer from ch0 upwards, and all_ready
    // must track "every channel released".
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (((rst_out_n & (rst_out_n + 3'd1)) != 3'd0) || (all_ready !== (&rst_out_n))) begin
                errors++;
                $display("FAIL monitor @%0t: rst_out_n=%b all_ready=%b, expected thermometer order and all_ready=%b",
                         $time, rst_out_n, all_ready, &rst_out_n);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion before 2000000");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        key_n      = 1'b1;
        wdog_kick  = 1'b0;

        //         rst  lock key cyc  rst_out  rdy   state
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 3, 3'b000, 1'b0, S_HOLD};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 2, 3'b000, 1'b0, S_HOLD};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1, 3'b000, 1'b0, S_DELAY};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 7, 3'b000, 1'b0, S_DELAY};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1, 3'b001, 1'b0, S_DELAY};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 7, 3'b001, 1'b0, S_DELAY};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1, 3'b011, 1'b0, S_DELAY};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 7, 3'b011, 1'b0, S_DELAY};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1, 3'b111, 1'b1, S_RUN};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 10, 3'b111, 1'b1, S_RUN};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3, 3'b111, 1'b1, S_RUN};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 5, 3'b111, 1'b1, S_RUN};

        for (int i = 0; i < 12; i++) begin
            reset_n    = vecs[i].rst_n;
            pll_locked = vecs[i].lock;
            key_n      = vecs[i].key;
            tick(vecs[i].cycles);
            check($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_ready, vecs[i].exp_state);
            mon_en = 1'b1;
        end

        // Key held long enough to be accepted, then released and re-debounced.
        key_n = 1'b0;
        tick(6);
        check("key_press_not_yet_accepted", 3'b111, 1'b1, S_RUN);
        tick(1);
        check("key_press_forces_hold", 3'b000, 1'b0, S_HOLD);
        key_n = 1'b1;
        tick(6);
        check("key_release_still_debouncing", 3'b000, 1'b0, S_HOLD);
        tick(1);
        check("key_release_restarts", 3'b000, 1'b0, S_DELAY);
        tick(7);
        check("key_reseq_ch0_not_yet", 3'b000, 1'b0, S_DELAY);
        tick(1);
        check("key_reseq_ch0", 3'b001, 1'b0, S_DELAY);
        tick(16);
        check("key_reseq_run", 3'b111, 1'b1, S_RUN);

        // One-cycle lock drop in RUN.
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("lock_drop_in_sync_chain", 3'b111, 1'b1, S_RUN);
        tick(1);
        check("lock_drop_forces_hold", 3'b000, 1'b0, S_HOLD);
        tick(1);
        check("lock_return_restarts", 3'b000, 1'b0, S_DELAY);
        tick(7);
        check("lock_reseq_ch0_not_yet", 3'b000, 1'b0, S_DELAY);
        tick(1);
        check("lock_reseq_ch0", 3'b001, 1'b0, S_DELAY);

        // Lock loss seen by the FSM exactly at the edge that would release ch2.
        tick(13);
        check("pre_final_release", 3'b011, 1'b0, S_DELAY);
        pll_locked = 1'b0;
        tick(2);
        check("final_release_pending", 3'b011, 1'b0, S_DELAY);
        tick(1);
        check("fault_beats_final_release", 3'b000, 1'b0, S_HOLD);

        // Restart, then synchronous reset with idx=1.
        pll_locked = 1'b1;
        tick(3);
        check("restart_after_lock", 3'b000, 1'b0, S_DELAY);
        tick(10);
        check("mid_delay_idx1", 3'b001, 1'b0, S_DELAY);
        reset_n = 1'b0;
        tick(1);
        check("reset_mid_delay", 3'b000, 1'b0, S_HOLD);
        reset_n = 1'b1;
        tick(2);
        check("post_reset_sync_wait", 3'b000, 1'b0, S_HOLD);
        tick(1);
        check("post_reset_restart", 3'b000, 1'b0, S_DELAY);
        tick(24);
        check("post_reset_run", 3'b111, 1'b1, S_RUN);

`ifdef RESET_SEQ_WDOG_EN
        tick(31);
        check("wdog_before_timeout", 3'b111, 1'b1, S_RUN);
        wdog_kick = 1'b1;
        tick(1);
        wdog_kick = 1'b0;
        check("wdog_kick_at_timeout", 3'b111, 1'b1, S_RUN);
        for (int k = 0; k < 5; k++) begin
            tick(19);
            wdog_kick = 1'b1;
            tick(1);
            wdog_kick = 1'b0;
            check($sformatf("wdog_kicked_run%0d", k), 3'b111, 1'b1, S_RUN);
        end
        tick(31);
        check("wdog_last_cycle", 3'b111, 1'b1, S_RUN);
        tick(1);
        check("wdog_timeout_hold", 3'b000, 1'b0, S_HOLD);
`else
        tick(40);
        check("no_wdog_run_a", 3'b111, 1'b1, S_RUN);
        wdog_kick = 1'b1;
        tick(1);
        wdog_kick = 1'b0;
        tick(60);
        check("no_wdog_run_b", 3'b111, 1'b1, S_RUN);
`endif

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
